c_dcdc_seq: RTL and testbench

Clocked, parametrised multi-channel DC-DC converter model with soft-start slew limiting, input UVLO, dropout tracking, debounced power-good, latched over-voltage fault and optional power-up sequencing. It is the next-generation successor to the single-channel `c_dcdc` behavioural model. It sits in the power-on (pon) simulation models and feeds rail voltages and status flags to the sequencer and monitor blocks. All voltages are signed fixed point at 0.01 V/LSB (3200 = 32.00 V).

---
 rtl/c_dcdc_seq.sv | 125 ++++++++++++
 tb/tb_c_dcdc_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/c_dcdc_seq.sv
`default_nettype none
// c_dcdc_seq: multi-channel DC-DC converter model with soft-start slew limiting,
// input UVLO, dropout tracking, debounced power-good, latched OV and sequencing.
module c_dcdc_seq #(
  parameter int W      = 16,
  parameter int NCH    = 4,
  parameter int SLEW   = 10,
  parameter int PG_TOL = 20,
  parameter int PG_DLY = 4,
  parameter int OV_TH  = 100,
  parameter int UVLO   = 450,
  parameter int SEQ    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] pin,
  input  logic [NCH-1:0]      en,
  input  logic [NCH*W-1:0]    vset,
  input  logic [NCH*W-1:0]    offset_pout,
  output logic [NCH*W-1:0]    pout,
  output logic [NCH-1:0]      pg,
  output logic [NCH-1:0]      ov
);
  localparam int XW = W + 2;
  localparam int CW = $clog2(PG_DLY + 1) + 1;

  typedef logic signed [XW-1:0] xw_t;
  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_RAMP  = 2'd1,
    S_REG   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam xw_t                 MAX_X  = xw_t'((1 << (W - 1)) - 1);
  localparam xw_t                 SLEW_X = xw_t'(SLEW);
  localparam xw_t                 TOL_X  = xw_t'(PG_TOL);
  localparam xw_t                 OVTH_X = xw_t'(OV_TH);
  localparam xw_t                 UVLO_X = xw_t'(UVLO);
  localparam logic signed [W-1:0] SLEW_W = W'(SLEW);
  localparam logic [CW-1:0]       DLY_C  = CW'(PG_DLY);

  xw_t  pin_x;
  xw_t  pin_clip;
  logic pin_ok;

  assign pin_x    = {{2{pin[W-1]}}, pin};
  assign pin_clip = pin[W-1] ? '0 : pin_x;
  assign pin_ok   = (pin_x >= UVLO_X);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t              state_q, state_d;
    logic signed [W-1:0] pout_q, pout_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                pg_q, pg_d, ov_q, ov_d;
    logic                seq_ok, in_win, ov_hit, active;
    xw_t                 vs, os, sum, tgt, eff, px, goal, delta;

    if (SEQ == 0 || i == 0) begin : g_free
      assign seq_ok = 1'b1;
    end else begin : g_seq
      assign seq_ok = pg[i-1];
    end

    always_comb begin
      vs     = {{2{vset[i*W+W-1]}}, vset[i*W +: W]};
      os     = {{2{offset_pout[i*W+W-1]}}, offset_pout[i*W +: W]};
      sum    = vs + os;
      tgt    = sum[XW-1] ? '0 : ((sum > MAX_X) ? MAX_X : sum);
      eff    = (tgt < pin_clip) ? tgt : pin_clip;
      px     = {{2{pout_q[W-1]}}, pout_q};
      active = (state_q == S_RAMP) || (state_q == S_REG);
      in_win = ((px - eff) <= TOL_X) && ((eff - px) <= TOL_X);
      ov_hit = (px - tgt) > OVTH_X;

      state_d = state_q;
      case (state_q)
        S_OFF: if (en[i] && pin_ok && seq_ok) state_d = S_RAMP;
        S_RAMP, S_REG: begin
          if (!en[i] || !pin_ok) state_d = S_OFF;
          else if (ov_hit)       state_d = S_FAULT;
          else if (px == eff)    state_d = S_REG;
        end
        S_FAULT: if (!en[i]) state_d = S_OFF;
        default: state_d = S_OFF;
      endcase

      goal  = active ? eff : '0;
      delta = goal - px;
      if (delta > SLEW_X)       pout_d = pout_q + SLEW_W;
      else if (delta < -SLEW_X) pout_d = pout_q - SLEW_W;
      else                      pout_d = goal[W-1:0];

      // Debounce also runs over the last ramp steps, so pg lands PG_DLY cycles
      // after the output first enters the window.
      cnt_d = '0;
      if (active && in_win && (state_d == S_RAMP || state_d == S_REG))
        cnt_d = (cnt_q >= DLY_C) ? cnt_q : cnt_q + 1'b1;
      pg_d = (state_d == S_REG) && (cnt_d >= DLY_C);
      ov_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_OFF;
        pout_q  <= '0;
        cnt_q   <= '0;
        pg_q    <= 1'b0;
        ov_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        pout_q  <= pout_d;
        cnt_q   <= cnt_d;
        pg_q    <= pg_d;
        ov_q    <= ov_d;
      end
    end

    assign pout[i*W +: W] = pout_q;
    assign pg[i]          = pg_q;
    assign ov[i]          = ov_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_c_dcdc_seq.sv
`default_nettype none
// Directed scoreboard bench for c_dcdc_seq with NCH=2, other parameters default.
module tb_c_dcdc_seq;
  localparam int W   = 16;
  localparam int NCH = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [W-1:0] pin;
  logic [NCH-1:0]      en;
  logic [NCH*W-1:0]    vset;
  logic [NCH*W-1:0]    offset_pout;
  logic [NCH*W-1:0]    pout;
  logic [NCH-1:0]      pg;
  logic [NCH-1:0]      ov;

  c_dcdc_seq #(.W(W), .NCH(NCH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin        (pin),
    .en         (en),
    .vset       (vset),
    .offset_pout(offset_pout),
    .pout       (pout),
    .pg         (pg),
    .ov         (ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    int             cyc;
    logic [W-1:0]   p0;
    logic [W-1:0]   p1;
    logic [1:0]     pg;
    logic [1:0]     ov;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   base = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  event smp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NCH*W-1:0] pk(input int a0, input int a1);
    return {W'(a1), W'(a0)};
  endfunction

  task automatic goto(input int k);
    while (cyc - base < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string nm, input int v0, input int v1,
                      input logic [1:0] g, input logic [1:0] o);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.p0 = W'(v0); e.p1 = W'(v1); e.pg = g; e.ov = o;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int k, input int v0, input int v1,
                     input logic [1:0] g, input logic [1:0] o);
    goto(k);
    push(nm, v0, v1, g, o);
  endtask

  task automatic check_front();
    exp_t e;
    e = q.pop_front();
    n_cmp++;
    if (pout[W-1:0] !== e.p0 || pout[2*W-1:W] !== e.p1 || pg !== e.pg || ov !== e.ov) begin
      n_bad++;
      $display("FAIL %s: got pout0=%0d pout1=%0d pg=%b ov=%b, expected pout0=%0d pout1=%0d pg=%b ov=%b",
               e.name, $signed(pout[W-1:0]), $signed(pout[2*W-1:W]), pg, ov,
               $signed(e.p0), $signed(e.p1), e.pg, e.ov);
    end
  endtask

  initial forever begin
    @(negedge clk or smp);
    while (q.size() > 0 && q[0].cyc <= cyc) check_front();
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    pin = 16'sd3200; en = '0; vset = '0; offset_pout = '0;

    // Reset and idle
    chk("rst_hold", 2, 0, 0, 2'b00, 2'b00);
    rst_n = 1'b1; base = cyc;
    chk("rst_idle", 5, 0, 0, 2'b00, 2'b00);

    // Asynchronous reset mid-ramp
    vset = pk(1200, 500); en = 2'b01; base = cyc;
    chk("ramp600", 61, 600, 0, 2'b00, 2'b00);
    @(negedge clk); #1; rst_n = 1'b0; #1;
    push("async_rst", 0, 0, 2'b00, 2'b00);
    -> smp;
    en = 2'b00; base = cyc;
    goto(3);
    rst_n = 1'b1; base = cyc;
    chk("post_rst", 2, 0, 0, 2'b00, 2'b00);

    // Power-up sequencing
    en = 2'b11; base = cyc;
    chk("seq_start",   1,    0,   0, 2'b00, 2'b00);
    chk("ramp_slew",   2,   10,   0, 2'b00, 2'b00);
    chk("ramp_mid",   60,  590,   0, 2'b00, 2'b00);
    chk("win_enter", 119, 1180,   0, 2'b00, 2'b00);
    chk("ramp_done", 121, 1200,   0, 2'b00, 2'b00);
    chk("pg0_wait",  122, 1200,   0, 2'b00, 2'b00);
    chk("pg0_on",    123, 1200,   0, 2'b01, 2'b00);
    chk("ch1_start", 124, 1200,   0, 2'b01, 2'b00);
    chk("ch1_slew",  125, 1200,  10, 2'b01, 2'b00);
    chk("ch1_done",  174, 1200, 500, 2'b01, 2'b00);
    chk("pg1_wait",  175, 1200, 500, 2'b01, 2'b00);
    chk("pg1_on",    176, 1200, 500, 2'b11, 2'b00);
    chk("settled",   200, 1200, 500, 2'b11, 2'b00);

    // Over-voltage fault via negative trim
    offset_pout = pk(-200, 0); base = cyc;
    chk("ov_trip",    1, 1190, 500, 2'b10, 2'b01);
    chk("ov_dis",     2, 1180, 500, 2'b10, 2'b01);
    chk("ov_dis50",  50,  700, 500, 2'b10, 2'b01);
    chk("ov_zero",  120,    0, 500, 2'b10, 2'b01);
    chk("ov_hold",  130,    0, 500, 2'b10, 2'b01);
    en = 2'b10; base = cyc;
    chk("ov_clear",   1,    0, 500, 2'b10, 2'b00);
    offset_pout = pk(0, 0); en = 2'b11; base = cyc;
    chk("re_ramp",    2,   10, 500, 2'b10, 2'b00);
    chk("re_pg",    123, 1200, 500, 2'b11, 2'b00);

    // UVLO shutdown and re-sequencing
    pin = 16'sd400; base = cyc;
    chk("uvlo_off",   1, 1190, 490, 2'b00, 2'b00);
    chk("uvlo_dis",   2, 1180, 480, 2'b00, 2'b00);
    chk("uvlo_mid",  50,  700,   0, 2'b00, 2'b00);
    chk("uvlo_zero",120,    0,   0, 2'b00, 2'b00);
    pin = 16'sd3200; base = cyc;
    chk("reseq0",     2,   10,   0, 2'b00, 2'b00);
    chk("reseq_pg0",123, 1200,   0, 2'b01, 2'b00);
    chk("reseq_ch1",125, 1200,  10, 2'b01, 2'b00);
    chk("reseq_pg1",176, 1200, 500, 2'b11, 2'b00);

    // Dropout tracking
    pin = 16'sd800; base = cyc;
    chk("drop_start",  1, 1190, 500, 2'b10, 2'b00);
    chk("drop_settle",40,  800, 500, 2'b10, 2'b00);
    chk("drop_pgwait",41,  800, 500, 2'b10, 2'b00);
    chk("drop_pg",    42,  800, 500, 2'b11, 2'b00);
    pin = 16'sd3200; base = cyc;
    chk("rise_start",  1,  810, 500, 2'b10, 2'b00);
    chk("rise_done",  40, 1200, 500, 2'b10, 2'b00);
    chk("rise_pgwait",41, 1200, 500, 2'b10, 2'b00);
    chk("rise_pg",    42, 1200, 500, 2'b11, 2'b00);

    // Trim tracking in regulation
    offset_pout = pk(100, 0); base = cyc;
    chk("trim_start",  1, 1210, 500, 2'b10, 2'b00);
    chk("trim_done",  10, 1300, 500, 2'b10, 2'b00);
    chk("trim_pgwait",11, 1300, 500, 2'b10, 2'b00);
    chk("trim_pg",    12, 1300, 500, 2'b11, 2'b00);

    // Disable coincident with an over-voltage condition
    offset_pout = pk(-300, 0); en = 2'b10; base = cyc;
    chk("en_ov_tie",   1, 1290, 500, 2'b10, 2'b00);
    chk("en_ov_off",   2, 1280, 500, 2'b10, 2'b00);

    repeat (3) @(negedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no sample, expected pout0=%0d pout1=%0d",
               e.name, $signed(e.p0), $signed(e.p1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
